// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: ID issue increments, WB commit decrements.
// Optional `SB_WB_BYPASS_EN: a register whose last pending write commits this cycle reads as ready.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic        issue_wen,
    input  logic [4:0]  issue_wnum,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_wnum,
    input  logic [1:0]  read_type,
    input  logic [4:0]  RR1,
    input  logic [4:0]  RR2,
    output logic        ready,
    output logic [31:0] busy_mask,
    output logic        err_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Register 0 is never tracked, so no storage exists for it.
    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic             err_q;
    logic             err_d;

    logic [CNT_W-1:0] cnt_iss;
    logic [CNT_W-1:0] cnt_wb;
    logic [CNT_W-1:0] cnt_rr1;
    logic [CNT_W-1:0] cnt_rr2;
    logic             wb_trk;
    logic             issue_sat;
    logic             inc_ok;
    logic             byp1;
    logic             byp2;
    logic             busy1;
    logic             busy2;
    logic             inc_n;
    logic             dec_n;

    always_comb begin
        cnt_iss   = '0;
        cnt_wb    = '0;
        cnt_rr1   = '0;
        cnt_rr2   = '0;
        wb_trk    = 1'b0;
        busy_mask = '0;
        for (int n = 1; n < NREG; n++) begin
            if (issue_wnum == 5'(n)) cnt_iss = cnt_q[n];
            if (wb_wnum == 5'(n)) begin
                cnt_wb = cnt_q[n];
                wb_trk = 1'b1;
            end
            if (RR1 == 5'(n)) cnt_rr1 = cnt_q[n];
            if (RR2 == 5'(n)) cnt_rr2 = cnt_q[n];
            busy_mask[n] = (cnt_q[n] != '0);
        end
    end

    // A same-cycle commit to the saturated destination frees the slot it needs.
    assign issue_sat   = issue_valid && issue_wen && (cnt_iss == CNT_MAX) &&
                         !(wb_valid && (wb_wnum == issue_wnum));
    assign issue_ready = !issue_sat;
    assign inc_ok      = issue_valid && issue_wen && !issue_sat;

`ifdef SB_WB_BYPASS_EN
    assign byp1 = wb_valid && (wb_wnum == RR1) && (cnt_rr1 == CNT_ONE);
    assign byp2 = wb_valid && (wb_wnum == RR2) && (cnt_rr2 == CNT_ONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign busy1 = (cnt_rr1 != '0) && !byp1;
    assign busy2 = (cnt_rr2 != '0) && !byp2;
    assign ready = !((read_type[0] && busy1) || (read_type[1] && busy2));

    always_comb begin
        inc_n = 1'b0;
        dec_n = 1'b0;
        for (int n = 1; n < NREG; n++) begin
            inc_n    = inc_ok && (issue_wnum == 5'(n));
            dec_n    = wb_valid && (wb_wnum == 5'(n)) && (cnt_q[n] != '0);
            cnt_d[n] = cnt_q[n];
            if (flush)
                cnt_d[n] = '0;
            else if (inc_n && !dec_n)
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            else if (dec_n && !inc_n)
                cnt_d[n] = cnt_q[n] - CNT_ONE;
        end
        err_d = err_q | (!flush && wb_valid && wb_trk && (cnt_wb == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 1; n < NREG; n++) cnt_q[n] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios then randomized traffic
// against a count-per-register reference model.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_wen = 1'b0;
    logic [4:0]  issue_wnum = '0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_wnum = '0;
    logic [1:0]  read_type = '0;
    logic [4:0]  RR1 = '0;
    logic [4:0]  RR2 = '0;
    logic        ready;
    logic [31:0] busy_mask;
    logic        err_underflow;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXCNT = 3;

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_wnum(issue_wnum),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_wnum(wb_wnum),
        .read_type(read_type), .RR1(RR1), .RR2(RR2),
        .ready(ready), .busy_mask(busy_mask), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        ir;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   cnt_m [32];
    bit   err_m;
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

    function automatic bit src_busy(input int r, input bit wv, input int wbn);
        if (r == 0 || cnt_m[r] == 0) return 1'b0;
        if (BYP && wv && wbn == r && cnt_m[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(input bit rs, input bit fl, input bit iv, input bit iw,
                         input int wn, input bit wv, input int wbn,
                         input logic [1:0] rt, input int r1, input int r2, input bit chk);
        exp_t e;
        bit   take;
        @(posedge clk);
        #1;
        rst = rs; flush = fl; issue_valid = iv; issue_wen = iw; issue_wnum = 5'(wn);
        wb_valid = wv; wb_wnum = 5'(wbn); read_type = rt; RR1 = 5'(r1); RR2 = 5'(r2);
        e.ir  = !(iv && iw && wn != 0 && cnt_m[wn] == MAXCNT && !(wv && wbn == wn));
        e.rdy = !((rt[0] && src_busy(r1, wv, wbn)) || (rt[1] && src_busy(r2, wv, wbn)));
        e.mask = '0;
        for (int n = 1; n < 32; n++) e.mask[n] = (cnt_m[n] != 0);
        e.err = err_m;
        if (chk) q.push_back(e);
        if (rs) begin
            for (int n = 0; n < 32; n++) cnt_m[n] = 0;
            err_m = 1'b0;
        end else if (fl) begin
            for (int n = 0; n < 32; n++) cnt_m[n] = 0;
        end else begin
            take = iv && iw && e.ir && wn != 0;
            if (wv && wbn != 0 && cnt_m[wbn] == 0) err_m = 1'b1;
            else if (wv && wbn != 0) cnt_m[wbn] -= 1;
            if (take) cnt_m[wn] += 1;
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (ready !== e.rdy) begin
                    miscompares++;
                    $display("FAIL ready vec %0d: got %b want %b", vectors, ready, e.rdy);
                end
                if (issue_ready !== e.ir) begin
                    miscompares++;
                    $display("FAIL issue_ready vec %0d: got %b want %b", vectors, issue_ready, e.ir);
                end
                if (busy_mask !== e.mask) begin
                    miscompares++;
                    $display("FAIL busy_mask vec %0d: got %h want %h", vectors, busy_mask, e.mask);
                end
                if (err_underflow !== e.err) begin
                    miscompares++;
                    $display("FAIL err_underflow vec %0d: got %b want %b", vectors, err_underflow, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int wn, wbn;
        for (int n = 0; n < 32; n++) cnt_m[n] = 0;
        err_m = 1'b0;
        cycle(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        // Post-reset query
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b11, 5, 6, 1);
        // Issue r5, observe busy, commit, observe release
        cycle(0, 0, 1, 1, 5, 0, 0, 2'b01, 5, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 5, 2'b01, 5, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1);
        // Saturate r7, blocked fourth issue, retry with same-cycle commit
        cycle(0, 0, 1, 1, 7, 0, 0, 2'b10, 0, 7, 1);
        cycle(0, 0, 1, 1, 7, 0, 0, 2'b10, 0, 7, 1);
        cycle(0, 0, 1, 1, 7, 0, 0, 2'b10, 0, 7, 1);
        cycle(0, 0, 1, 1, 7, 0, 0, 2'b10, 0, 7, 1);
        cycle(0, 0, 1, 1, 7, 1, 7, 2'b10, 0, 7, 1);
        cycle(0, 0, 0, 0, 0, 1, 7, 2'b10, 0, 7, 1);
        cycle(0, 0, 0, 0, 0, 1, 7, 2'b10, 0, 7, 1);
        cycle(0, 0, 0, 0, 0, 1, 7, 2'b10, 0, 7, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 7, 1);
        // Register 0 is never tracked
        cycle(0, 0, 1, 1, 0, 0, 0, 2'b11, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 2'b11, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 1);
        // Underflow on r9, sticky across flush
        cycle(0, 0, 0, 0, 0, 1, 9, 2'b01, 9, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 2'b01, 9, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0, 1);
        // Flush overrides same-cycle issue and commit
        cycle(0, 0, 1, 1, 3, 0, 0, 2'b11, 3, 4, 1);
        cycle(0, 0, 1, 1, 4, 0, 0, 2'b11, 3, 4, 1);
        cycle(0, 1, 1, 1, 3, 1, 4, 2'b11, 3, 4, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 4, 1);
        // Reset clears the sticky flag
        cycle(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 4, 1);
        // Randomized traffic over a small register window to force contention
        for (int i = 0; i < 3000; i++) begin
            wn  = int'($urandom_range(0, 7));
            wbn = int'($urandom_range(0, 7));
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0), wn,
                  ($urandom_range(0, 9) < 4), wbn, 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard for the in-order MIPS pipeline, replacing per-stage destination comparison with tracked state. The ID stage increments a register's pending count when it issues a writing instruction; WB decrements it on commit. Source-operand queries return `ready` only when no earlier in-flight instruction still owes a write to a requested source. The block sits beside the ID stage and is fed by the ID issue handshake and the WB commit port.

## Interface

Parameters:
- `CNT_W`, 2: width of each per-register pending counter; max in-flight writes per register = 2^CNT_W − 1.
- `NREG`, 32: number of architectural GPRs; register 0 is never tracked.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `flush`  input  1  pipeline flush; clears all pending counts.
- `issue_valid`  input  1  ID issues an instruction this cycle.
- `issue_wen`  input  1  issued instruction writes a GPR.
- `issue_wnum`  input  5  destination register of the issued instruction.
- `issue_ready`  output  1  issue accepted; low when the destination counter is saturated.
- `wb_valid`  input  1  WB commits a GPR write this cycle.
- `wb_wnum`  input  5  destination register being committed.
- `read_type`  input  2  bit0: RR1 is read; bit1: RR2 is read; 00: no check.
- `RR1`, `RR2`  input  5  source register numbers of the instruction in ID.
- `ready`  output  1  all requested sources are free of pending writes.
- `busy_mask`  output  32  bit n = 1 when register n has a nonzero pending count.
- `err_underflow`  output  1  sticky; set when a commit hits a zero counter.

## Operation

- State: `NREG` counters `cnt[n]`, each `CNT_W` bits; `cnt[0]` is hard-wired 0. One sticky `err_underflow` flop.
- Increment condition `inc[n]` = `issue_valid && issue_wen && issue_ready && issue_wnum==n && n!=0`.
- Decrement condition `dec[n]` = `wb_valid && wb_wnum==n && n!=0 && cnt[n]!=0`.
- Next state: inc only → +1; dec only → −1; both → unchanged; neither → unchanged. No wrap in either direction.
- `issue_ready` = !(`issue_wen` && `issue_wnum`!=0 && `cnt[issue_wnum]`==max && !(`wb_valid` && `wb_wnum`==`issue_wnum`)). A same-cycle commit to a saturated register frees the slot. `issue_ready` = 1 when `issue_valid`=0.
- `wb_valid` with `cnt[wb_wnum]`==0 and `wb_wnum`!=0: counter stays 0, `err_underflow` set at the next edge, cleared only by `rst`.
- Query: `src_busy(r)` = (r!=0) && `cnt[r]`!=0 (modified by `SB_WB_BYPASS_EN`). `ready` = !((`read_type[0]` && `src_busy(RR1)`) || (`read_type[1]` && `src_busy(RR2)`)). The query reflects the current state only and is unaffected by the same-cycle issue.
- `flush`: all counters zero at the next edge. Issue and commit in the same cycle are ignored. `err_underflow` is held.
- `rst`: all counters 0, `err_underflow` 0. Has priority over `flush`, issue and commit.

## Timing

- State update: one cycle. Issue at edge k is visible to `ready` and `busy_mask` from cycle k+1.
- `ready`, `issue_ready` and `busy_mask` are combinational from the current state and current inputs. No registered outputs.
- Output values after reset: `busy_mask`=0, `err_underflow`=0, `ready`=1, `issue_ready`=1.
- Write to register 0: never counted, never blocks, never flags underflow.

## Configuration

- `SB_WB_BYPASS_EN` defined: `src_busy(r)` additionally requires !(`wb_valid` && `wb_wnum`==r && `cnt[r]`==1). A register whose last pending write commits this cycle reads as ready, which relies on the register file's write-through forwarding.
- Undefined: `src_busy(r)` is based on `cnt[r]` only, so a committing register is ready one cycle later.

## Test plan

- Reset, then `read_type`=11, `RR1`=5, `RR2`=6 → `ready`=1, `busy_mask`=0, `issue_ready`=1.
- Issue write to r5, next cycle query `RR1`=5 with `read_type`=01 → `ready`=0, `busy_mask`[5]=1. WB commits r5 → `ready`=1 the cycle after; with `SB_WB_BYPASS_EN`, `ready`=1 during the commit cycle itself.
- Issue r7 three times (CNT_W=2) → `cnt`=3; fourth issue → `issue_ready`=0, count stays 3. Fourth issue retried with a same-cycle r7 commit → `issue_ready`=1, count stays 3.
- Issue to r0 with `read_type`=11, `RR1`=`RR2`=0 → `ready`=1, `busy_mask`=0. Commit r0 → `err_underflow` stays 0.
- Commit r9 with `cnt[9]`=0 → `err_underflow`=1 from the next cycle, `cnt[9]`=0. Flag persists across `flush`; cleared by `rst`.
- r3 and r4 pending, `flush` asserted with a simultaneous r3 issue and r4 commit → `busy_mask`=0 next cycle, `ready`=1 for `RR1`=3, `RR2`=4.
